// File: rtl/smi_flit_scale_d2_pkg.sv
// Shared definitions for the SMI x2-down flit scaler.
//  - SMI eofc width and the "not last" eofc value (shared with the x2 scaler)
//  - split FSM state encoding
//  - eofc clamp helper
package smi_flit_scale_d2_pkg;

    localparam int         SMI_EOFC_WIDTH = 8;
    localparam logic [7:0] SMI_EOFC_NONE  = 8'd0;

    // LOW : next emitted flit is the low half of the input register
    // HIGH: next emitted flit is the stored high half
    typedef enum logic {
        SPLIT_LOW  = 1'b0,
        SPLIT_HIGH = 1'b1
    } split_state_t;

    // Out-of-range byte counts saturate to the full wide-flit size.
    function automatic logic [SMI_EOFC_WIDTH-1:0] eofc_clamp(
        input logic [SMI_EOFC_WIDTH-1:0] e,
        input logic [SMI_EOFC_WIDTH-1:0] limit
    );
        return (e > limit) ? limit : e;
    endfunction

endpackage

// File: rtl/selfLinkBufferFifoS.sv
// Fall-through (show-ahead) SMI link buffer FIFO.
// Ports:
//  clk, srst    clock, asynchronous active-high reset (empties the FIFO)
//  i_in_valid   write request
//  o_in_stop    FIFO full, write is refused
//  i_in_data    write data
//  o_out_valid  head entry valid
//  o_out_data   head entry data
//  i_out_stop   consumer backpressure
// Handshake on both sides: a word moves on a cycle with valid=1 and stop=0;
// while stopped the sender keeps valid and data unchanged.
module selfLinkBufferFifoS #(
    parameter int Width         = 40,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_in_valid,
    output logic             o_in_stop,
    input  logic [Width-1:0] i_in_data,
    output logic             o_out_valid,
    output logic [Width-1:0] o_out_data,
    input  logic             i_out_stop
);

    localparam logic [FifoIndexSize-1:0] LastIdx = FifoIndexSize'(FifoSize - 1);
    localparam logic [FifoIndexSize:0]   Full    = (FifoIndexSize + 1)'(FifoSize);

    logic [Width-1:0]         r_mem [FifoSize];
    logic [FifoIndexSize-1:0] r_wr_ptr;
    logic [FifoIndexSize-1:0] r_rd_ptr;
    logic [FifoIndexSize:0]   r_count;
    logic                     w_push;
    logic                     w_pop;

    assign o_in_stop   = (r_count == Full);
    assign o_out_valid = (r_count != '0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign w_push      = i_in_valid & ~o_in_stop;
    assign w_pop       = o_out_valid & ~i_out_stop;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LastIdx) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LastIdx) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_in_data;
    end

endmodule

// File: rtl/smi_flit_scale_d2.sv
// SMI flit width halving: each 2*FlitWidth-byte input flit leaves as one or
// two FlitWidth-byte flits (low half first). Frame boundaries and eofc are kept.
// Ports:
//  clk, srst     clock, asynchronous active-high reset
//  smiInReady    input flit valid
//  smiInEofc     input eofc (0 = not last, else byte count on last flit)
//  smiInData     input flit, low half is emitted first
//  smiInStop     input backpressure
//  smiOutReady   output flit valid (FIFO head)
//  smiOutEofc    output eofc
//  smiOutData    output flit
//  smiOutStop    output backpressure
// Handshake on every stage: a flit moves on a cycle with Ready=1 and Stop=0;
// a stalled stage holds all of its registers.
module smi_flit_scale_d2 import smi_flit_scale_d2_pkg::*; #(
    parameter int FlitWidth     = 4,
    parameter int FifoSize      = 16,
    parameter int FifoIndexSize = 4
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     smiInReady,
    input  logic [7:0]               smiInEofc,
    input  logic [FlitWidth*16-1:0]  smiInData,
    output logic                     smiInStop,
    output logic                     smiOutReady,
    output logic [7:0]               smiOutEofc,
    output logic [FlitWidth*8-1:0]   smiOutData,
    input  logic                     smiOutStop
);

    localparam int         DW       = FlitWidth * 8;
    localparam logic [7:0] EofcMask = 8'(4 * FlitWidth - 1);
    localparam logic [7:0] FullEofc = 8'(2 * FlitWidth);
    localparam logic [7:0] HalfEofc = 8'(FlitWidth);

    // Input register stage
    logic          r_in_valid;
    logic [7:0]    r_in_eofc;
    logic          r_in_last;
    logic [2*DW-1:0] r_in_data;

    // Split stage
    split_state_t  r_state, w_state_d;
    logic          r_split_valid, w_split_valid_d;
    logic [7:0]    r_split_eofc, w_split_eofc_d;
    logic [DW-1:0] r_split_data, w_split_data_d;
    logic [DW-1:0] r_hi_data, w_hi_data_d;
    logic [7:0]    r_hi_eofc, w_hi_eofc_d;

    logic          w_fifo_halt;
    logic          w_split_adv;
    logic          w_in_halt;
    logic          w_in_load;
    logic [DW+7:0] w_fifo_out;

    assign w_split_adv = ~(r_split_valid & w_fifo_halt);
    // In HIGH the input register is held: its flit was already consumed and
    // the next one must wait until the stored high half has been emitted.
    assign w_in_halt   = (r_split_valid & w_fifo_halt) | (r_state == SPLIT_HIGH);
    assign w_in_load   = ~(r_in_valid & w_in_halt);
    assign smiInStop   = r_in_valid & w_in_halt;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) r_in_valid <= 1'b0;
        else if (w_in_load) r_in_valid <= smiInReady;
    end

    always_ff @(posedge clk) begin
        if (w_in_load) begin
            r_in_eofc <= eofc_clamp(smiInEofc & EofcMask, FullEofc);
            r_in_last <= (smiInEofc != SMI_EOFC_NONE);
            r_in_data <= smiInData;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state       <= SPLIT_LOW;
            r_split_valid <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_split_valid <= w_split_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        r_split_eofc <= w_split_eofc_d;
        r_split_data <= w_split_data_d;
        r_hi_data    <= w_hi_data_d;
        r_hi_eofc    <= w_hi_eofc_d;
    end

    always_comb begin
        w_state_d       = r_state;
        w_split_valid_d = r_split_valid;
        w_split_eofc_d  = r_split_eofc;
        w_split_data_d  = r_split_data;
        w_hi_data_d     = r_hi_data;
        w_hi_eofc_d     = r_hi_eofc;
        if (w_split_adv) begin
            case (r_state)
                SPLIT_LOW: begin
                    if (!r_in_valid) begin
                        w_split_valid_d = 1'b0;
                    end else begin
                        w_split_valid_d = 1'b1;
                        w_split_data_d  = r_in_data[DW-1:0];
                        if (!r_in_last) begin
                            w_split_eofc_d = SMI_EOFC_NONE;
                            w_hi_data_d    = r_in_data[2*DW-1:DW];
                            w_hi_eofc_d    = SMI_EOFC_NONE;
                            w_state_d      = SPLIT_HIGH;
                        end else if (r_in_eofc <= HalfEofc) begin
                            // Whole frame tail fits in the low half; high half is dropped.
                            w_split_eofc_d = r_in_eofc;
                        end else begin
                            w_split_eofc_d = SMI_EOFC_NONE;
                            w_hi_data_d    = r_in_data[2*DW-1:DW];
                            w_hi_eofc_d    = r_in_eofc - HalfEofc;
                            w_state_d      = SPLIT_HIGH;
                        end
                    end
                end
                SPLIT_HIGH: begin
                    w_split_valid_d = 1'b1;
                    w_split_data_d  = r_hi_data;
                    w_split_eofc_d  = r_hi_eofc;
                    w_state_d       = SPLIT_LOW;
                end
                default: w_state_d = SPLIT_LOW;
            endcase
        end
    end

    selfLinkBufferFifoS #(
        .Width         (DW + 8),
        .FifoSize      (FifoSize),
        .FifoIndexSize (FifoIndexSize)
    ) smiBufOut (
        .clk         (clk),
        .srst        (srst),
        .i_in_valid  (r_split_valid),
        .o_in_stop   (w_fifo_halt),
        .i_in_data   ({r_split_eofc, r_split_data}),
        .o_out_valid (smiOutReady),
        .o_out_data  (w_fifo_out),
        .i_out_stop  (smiOutStop)
    );

    assign {smiOutEofc, smiOutData} = w_fifo_out;

endmodule

// File: tb/tb_smi_flit_scale_d2.sv
module tb_smi_flit_scale_d2;

    logic        clk = 1'b0;
    logic        srst;
    logic        smiInReady;
    logic [7:0]  smiInEofc;
    logic [63:0] smiInData;
    logic        smiInStop;
    logic        smiOutReady;
    logic [7:0]  smiOutEofc;
    logic [31:0] smiOutData;
    logic        smiOutStop;

    always #5 clk = ~clk;

    smi_flit_scale_d2 #(
        .FlitWidth     (4),
        .FifoSize      (16),
        .FifoIndexSize (4)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInReady  (smiInReady),
        .smiInEofc   (smiInEofc),
        .smiInData   (smiInData),
        .smiInStop   (smiInStop),
        .smiOutReady (smiOutReady),
        .smiOutEofc  (smiOutEofc),
        .smiOutData  (smiOutData),
        .smiOutStop  (smiOutStop)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;
    int          outs = 0;
    bit          rand_stop = 0;
    int          hold_stop = 0;
    bit          saw_in_stop = 0;
    bit          hi_check = 0;
    bit          seen_out = 0;

    // Output scoreboard: every accepted narrow flit must match the queue head.
    always @(negedge clk) begin
        if (!srst && hi_check && seen_out && exp_q.size() != 0) begin
            checks++;
            assert (smiOutReady === 1'b1) else begin
                failures++;
                $error("FAIL out_ready_gap got=%b expected=1", smiOutReady);
            end
        end
        if (!srst && smiOutReady && !smiOutStop) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL out_unexpected got=%h expected=none", {smiOutEofc, smiOutData});
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checks++;
                assert ({smiOutEofc, smiOutData} === mon_exp) else begin
                    failures++;
                    $error("FAIL out_flit got=%h expected=%h", {smiOutEofc, smiOutData}, mon_exp);
                end
            end
            outs++;
            seen_out = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold_stop > 0) begin
            hold_stop--;
            smiOutStop = (hold_stop > 0);
        end else begin
            smiOutStop = rand_stop ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (smiInStop) saw_in_stop = 1;
    endtask

    // Expected narrow flits for one wide flit, straight from the splitting rules.
    task automatic model_push(input logic [63:0] d, input logic [7:0] e);
        logic [7:0] em;
        em = e & 8'h0F;
        if (em > 8'd8) em = 8'd8;
        if (e == 8'd0) begin
            exp_q.push_back({8'd0, d[31:0]});
            exp_q.push_back({8'd0, d[63:32]});
        end else if (em <= 8'd4) begin
            exp_q.push_back({em, d[31:0]});
        end else begin
            exp_q.push_back({8'd0, d[31:0]});
            exp_q.push_back({em - 8'd4, d[63:32]});
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] e);
        bit ok;
        bit acc;
        ok = 0;
        smiInReady = 1'b1;
        smiInData  = d;
        smiInEofc  = e;
        for (int i = 0; i < 300; i++) begin
            acc = !smiInStop;
            tick();
            if (acc) begin
                ok = 1;
                break;
            end
        end
        checks++;
        assert (ok) else begin
            failures++;
            $error("FAIL in_accept_timeout got=%b expected=1", ok);
        end
    endtask

    task automatic send_m(input logic [63:0] d, input logic [7:0] e);
        model_push(d, e);
        send(d, e);
    endtask

    task automatic drain(input string tag, input int base, input int n);
        smiInReady = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
        for (int i = 0; i < 6; i++) tick();
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_drain got=%0d expected=0 pending", tag, exp_q.size());
        end
        checks++;
        assert (outs - base == n) else begin
            failures++;
            $error("FAIL %s_count got=%0d expected=%0d", tag, outs - base, n);
        end
    endtask

    task automatic random_frame();
        int len;
        len = $urandom_range(1, 5);
        for (int i = 0; i < len - 1; i++) send_m({$urandom(), $urandom()}, 8'd0);
        send_m({$urandom(), $urandom()}, 8'($urandom_range(1, 15)));
    endtask

    initial begin
        int base;
        int n_exp;
        srst = 1'b1;
        smiInReady = 1'b0;
        smiInEofc = 8'd0;
        smiInData = '0;
        smiOutStop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (smiOutReady === 1'b0) else begin
            failures++;
            $error("FAIL reset_out_ready got=%b expected=0", smiOutReady);
        end
        checks++;
        assert (smiInStop === 1'b0) else begin
            failures++;
            $error("FAIL reset_in_stop got=%b expected=0", smiInStop);
        end
        srst = 1'b0;
        tick();

        // 1: not-last then last
        base = outs;
        exp_q.push_back({8'd0, 32'h2222_2222});
        exp_q.push_back({8'd0, 32'h1111_1111});
        exp_q.push_back({8'd0, 32'h4444_4444});
        exp_q.push_back({8'd4, 32'h3333_3333});
        send(64'h1111_1111_2222_2222, 8'd0);
        send(64'h3333_3333_4444_4444, 8'd8);
        drain("t1", base, 4);

        // 2: short last flit, high half dropped
        base = outs;
        exp_q.push_back({8'd3, 32'hCCCC_DDDD});
        send(64'hAAAA_BBBB_CCCC_DDDD, 8'd3);
        drain("t2", base, 1);

        // 3: split last flit, and an over-range eofc saturating to 8
        base = outs;
        exp_q.push_back({8'd0, 32'h7777_8888});
        exp_q.push_back({8'd1, 32'h5555_6666});
        exp_q.push_back({8'd0, 32'hBBBB_CCCC});
        exp_q.push_back({8'd4, 32'h9999_AAAA});
        send(64'h5555_6666_7777_8888, 8'd5);
        send(64'h9999_AAAA_BBBB_CCCC, 8'd12);
        drain("t3", base, 4);

        // 4: output held off for 30 cycles under a 10-flit frame
        base = outs;
        saw_in_stop = 0;
        smiOutStop = 1'b1;
        hold_stop = 30;
        for (int i = 0; i < 9; i++) send_m({$urandom(), $urandom()}, 8'd0);
        send_m({$urandom(), $urandom()}, 8'd8);
        checks++;
        assert (saw_in_stop == 1'b1) else begin
            failures++;
            $error("FAIL t4_in_stop got=%b expected=1", saw_in_stop);
        end
        drain("t4", base, 20);

        // 5a: random frames, random output stop
        base = outs;
        rand_stop = 1;
        for (int f = 0; f < 6; f++) random_frame();
        n_exp = outs - base + exp_q.size();
        drain("t5a", base, n_exp);
        rand_stop = 0;
        smiOutStop = 1'b0;

        // 5b: back-to-back frames, no stop: output must never bubble
        base = outs;
        seen_out = 0;
        hi_check = 1;
        for (int f = 0; f < 4; f++) random_frame();
        n_exp = outs - base + exp_q.size();
        drain("t5b", base, n_exp);
        hi_check = 0;

        // 6: reset while the splitter holds a stored high half
        send(64'hDEAD_BEEF_0BAD_F00D, 8'd0);
        smiInData = 64'h1234_5678_9ABC_DEF0;
        smiInEofc = 8'd8;
        smiInReady = 1'b1;
        tick();
        checks++;
        assert (smiInStop === 1'b1) else begin
            failures++;
            $error("FAIL t6_pre_stop got=%b expected=1", smiInStop);
        end
        srst = 1'b1;
        #1;
        checks++;
        assert (smiOutReady === 1'b0) else begin
            failures++;
            $error("FAIL t6_out_ready got=%b expected=0", smiOutReady);
        end
        checks++;
        assert (smiInStop === 1'b0) else begin
            failures++;
            $error("FAIL t6_in_stop got=%b expected=0", smiInStop);
        end
        exp_q.delete();
        smiInReady = 1'b0;
        tick();
        tick();
        srst = 1'b0;
        tick();
        base = outs;
        send_m(64'h0101_0202_0303_0404, 8'd0);
        send_m(64'h0505_0606_0707_0808, 8'd6);
        drain("t6", base, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
